// File: rtl/core_pkg.sv
// Shared definitions for the core control sequencer: state encoding,
// datapath width and the decoder class-flag bundle.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_IDLE   = 3'd5;
   localparam logic [2:0] ST_FAULT  = 3'd7;

   typedef enum logic [2:0] {
      FETCH  = ST_FETCH,
      DECODE = ST_DECODE,
      EXEC   = ST_EXEC,
      MEM    = ST_MEM,
      WB     = ST_WB,
      IDLE   = ST_IDLE,
      FAULT  = ST_FAULT
   } state_e;

   typedef struct packed {
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic alu;
   } iclass_t;

   // Classes that produce a register-file result at writeback.
   function automatic logic writes_rf(input iclass_t c);
      return c.alu | c.jump | c.load;
   endfunction

endpackage

// File: rtl/bus_timer.sv
// Bus-wait watchdog: a down-counter reloaded on clear, decremented while the
// bus is stalled, flagging expiry at terminal count zero.
module bus_timer
   import core_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = LOAD_VAL;
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= LOAD_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback; owns PC, instruction register and instret.
//
// state  | meaning
// FETCH  | imem request outstanding, waiting for imem_ack
// DECODE | register operands read, class flags checked for legality
// EXEC   | execute stage registers its result, pick MEM or WB
// MEM    | dmem request outstanding, waiting for dmem_ack
// WB     | rf write strobe, pc/instret update, halt sampled
// IDLE   | parked on halt, no requests
// FAULT  | terminal until reset
module core_ctrl
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned     MEM_TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            halt_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] instr_o,
   input  logic            is_load_i,
   input  logic            is_store_i,
   input  logic            is_branch_i,
   input  logic            is_jump_i,
   input  logic            is_alu_i,
   input  logic [XLEN-1:0] next_pc_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   input  logic            dmem_ack_i,
   output logic            rf_we_o,
   output logic [XLEN-1:0] pc_o,
   output logic [2:0]      state_o,
   output logic            halted_o,
   output logic            fault_o,
   output logic [XLEN-1:0] instret_o
);

   iclass_t         flags;
   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instret_q, instret_d;
   logic            fault_q;
   logic            run_q;
   logic            st_q, st_d;
   logic            wr_q, wr_d;
   logic            in_wait;
   logic            cur_ack;
   logic            expired;

   assign flags = {is_load_i, is_store_i, is_branch_i, is_jump_i, is_alu_i};

   // run_q keeps the reset-state FETCH from requesting until the first edge
   // after reset release.
   assign in_wait = run_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
   assign cur_ack = (state_q == ST_MEM) ? dmem_ack_i : imem_ack_i;

   bus_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_bus_timer (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clear_i  (!in_wait),
      .enable_i (in_wait && !cur_ack),
      .expired_o(expired)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      instret_d = instret_q;
      st_d      = st_q;
      wr_d      = wr_q;
      case (state_q)
         ST_FETCH: begin
            if (run_q) begin
               if (imem_ack_i) begin
                  instr_d = imem_rdata_i;
                  state_d = ST_DECODE;
               end else if (expired) begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_DECODE: begin
            st_d    = flags.store;
            wr_d    = writes_rf(flags);
            state_d = (flags == '0) ? ST_FAULT : ST_EXEC;
         end
         ST_EXEC: begin
            st_d    = flags.store;
            wr_d    = writes_rf(flags);
            state_d = (flags.load || flags.store) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            if (dmem_ack_i) begin
               state_d = ST_WB;
            end else if (expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_WB: begin
            pc_d      = next_pc_i;
            instret_d = instret_q + XLEN'(1);
            if (next_pc_i[1:0] != 2'b00) begin
               state_d = ST_FAULT;
            end else if (halt_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_IDLE: begin
            if (!halt_i) begin
               state_d = ST_FETCH;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         instret_q <= '0;
         fault_q   <= 1'b0;
         run_q     <= 1'b0;
         st_q      <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
         fault_q   <= fault_q | (state_d == ST_FAULT);
         run_q     <= 1'b1;
         st_q      <= st_d;
         wr_q      <= wr_d;
      end
   end

   assign imem_req_o  = run_q && (state_q == ST_FETCH);
   assign imem_addr_o = pc_q;
   assign dmem_req_o  = (state_q == ST_MEM);
   assign dmem_we_o   = (state_q == ST_MEM) && st_q;
   assign rf_we_o     = (state_q == ST_WB) && wr_q;
   assign instr_o     = instr_q;
   assign pc_o        = pc_q;
   assign state_o     = state_q;
   assign halted_o    = (state_q == ST_IDLE);
   assign fault_o     = fault_q;
   assign instret_o   = instret_q;

endmodule
